// File: rtl/bank_pkg.sv
// Shared constants for the bank request path: issue opcodes, line states
// and the index of each request source in the arbitration vectors.
package bank_pkg;

    localparam int NUM_SRC = 4;

    // Source indices; lower index wins when several compete.
    localparam int SRC_LF = 0;
    localparam int SRC_WB = 1;
    localparam int SRC_WR = 2;
    localparam int SRC_RD = 3;

    // Issue opcodes towards the SRAM controller.
    localparam logic [2:0] OP_WRITE = 3'd0;
    localparam logic [2:0] OP_READ  = 3'd1;
    localparam logic [2:0] OP_RD_LF = 3'd2;
    localparam logic [2:0] OP_WB    = 3'd3;

    // Cache line states carried in the dirty fields.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_SYNC  = 2'd1;
    localparam logic [1:0] ST_DIRTY = 2'd2;

endpackage : bank_pkg

// File: rtl/bank_age_arbiter.sv
// Fixed-priority arbiter (LF > WB > WR > RD) with per-source age counters.
// A source that has lost AGE_MAX accepting arbitrations becomes aged, and
// aged sources alone compete, which bounds starvation.
module bank_age_arbiter
    import bank_pkg::*;
#(
    parameter int AGE_W   = 3,
    parameter int AGE_MAX = 4
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [NUM_SRC-1:0] valid,
    input  logic               load_en,
    output logic [NUM_SRC-1:0] grant
);

    logic [AGE_W-1:0]   age [NUM_SRC];
    logic [NUM_SRC-1:0] aged;
    logic [NUM_SRC-1:0] compete;

    // Decide which sources compete: aged ones if any exist, else all valid ones.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        aged = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            aged[i] = valid[i] && (age[i] == AGE_W'(AGE_MAX));
        end
        compete = (|aged) ? aged : valid;
    end

    // Pick the lowest-index competitor as the one-hot grant.
    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (compete[i] && (grant == '0)) begin
                grant[i] = 1'b1;
            end
        end
    end

    // Age each waiting source on every accepting cycle it loses; clear on win or idle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                // NOTE: sequential state uses non-blocking assignments so all counters update from pre-edge values.
                if (valid[i] && load_en && !grant[i]) begin
                    if (age[i] != AGE_W'(AGE_MAX)) begin
                        age[i] <= age[i] + AGE_W'(1);
                    end
                end else if (!valid[i] || (grant[i] && load_en)) begin
                    age[i] <= '0;
                end
            end
        end
    end

endmodule : bank_age_arbiter

// File: rtl/bank_isu_scheduler.sv
// Issue scheduler: arbitrates line-fill, write-back, write and read requests
// into one registered issue entry towards the bank SRAM controller. The entry
// is held stable until the controller accepts it.
module bank_isu_scheduler
    import bank_pkg::*;
#(
    parameter int SWO_W   = 7,
    parameter int DATA_W  = 128,
    parameter int AGE_W   = 3,
    parameter int AGE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    // line-fill return
    input  logic              lf_valid_i,
    output logic              lf_ready_o,
    input  logic [SWO_W-1:0]  lf_swo_i,
    input  logic [1:0]        lf_ch_i,
    input  logic [2:0]        lf_rob_i,
    input  logic [1:0]        lf_dirty0_i,
    input  logic [1:0]        lf_dirty1_i,
    input  logic [DATA_W-1:0] lf_data0_i,
    input  logic [DATA_W-1:0] lf_data1_i,
    // write-back eviction
    input  logic              wb_valid_i,
    output logic              wb_ready_o,
    input  logic [SWO_W-1:0]  wb_swo_i,
    input  logic [1:0]        wb_dirty0_i,
    input  logic [1:0]        wb_dirty1_i,
    // write-buffer write
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [SWO_W-1:0]  wr_swo_i,
    input  logic [7:0]        wr_wbuf_id_i,
    // xbar read
    input  logic              rd_valid_i,
    output logic              rd_ready_o,
    input  logic [SWO_W-1:0]  rd_swo_i,
    input  logic [1:0]        rd_ch_i,
    input  logic [2:0]        rd_rob_i,
    // issue port to SRAM controller
    output logic              isu_sc_valid_o,
    input  logic              isu_sc_ready_i,
    output logic [2:0]        isu_sc_opcode_o,
    output logic [SWO_W-1:0]  isu_sc_set_way_offset_o,
    output logic [1:0]        isu_sc_channel_id_o,
    output logic [2:0]        isu_sc_xbar_rob_num_o,
    output logic [7:0]        isu_sc_wbuffer_id_o,
    output logic [1:0]        isu_sc_cacheline_dirty_offset0_o,
    output logic [1:0]        isu_sc_cacheline_dirty_offset1_o,
    output logic [DATA_W-1:0] isu_sc_linefill_data_offset0_o,
    output logic [DATA_W-1:0] isu_sc_linefill_data_offset1_o
);

    logic               load_en;
    logic [NUM_SRC-1:0] valid;
    logic [NUM_SRC-1:0] grant;

    logic [2:0]         nxt_opcode;
    logic [SWO_W-1:0]   nxt_swo;
    logic [1:0]         nxt_ch;
    logic [2:0]         nxt_rob;
    logic [7:0]         nxt_wbuf_id;
    logic [1:0]         nxt_dirty0;
    logic [1:0]         nxt_dirty1;
    logic [DATA_W-1:0]  nxt_data0;
    logic [DATA_W-1:0]  nxt_data1;

    // The issue register may take a new entry when empty or being drained.
    assign load_en = ~isu_sc_valid_o | isu_sc_ready_i;

    assign valid[SRC_LF] = lf_valid_i;
    assign valid[SRC_WB] = wb_valid_i;
    assign valid[SRC_WR] = wr_valid_i;
    assign valid[SRC_RD] = rd_valid_i;

    bank_age_arbiter #(
        .AGE_W   (AGE_W),
        .AGE_MAX (AGE_MAX)
    ) u_arb (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .valid   (valid),
        .load_en (load_en),
        .grant   (grant)
    );

    assign lf_ready_o = grant[SRC_LF] & load_en;
    assign wb_ready_o = grant[SRC_WB] & load_en;
    assign wr_ready_o = grant[SRC_WR] & load_en;
    assign rd_ready_o = grant[SRC_RD] & load_en;

    // Select the winner's fields; fields a source does not own are zero.
    always_comb begin
        nxt_opcode  = OP_WRITE;
        nxt_swo     = '0;
        nxt_ch      = '0;
        nxt_rob     = '0;
        nxt_wbuf_id = '0;
        nxt_dirty0  = ST_EMPTY;
        nxt_dirty1  = ST_EMPTY;
        nxt_data0   = '0;
        nxt_data1   = '0;
        if (grant[SRC_LF]) begin
            nxt_opcode = OP_RD_LF;
            nxt_swo    = lf_swo_i;
            nxt_ch     = lf_ch_i;
            nxt_rob    = lf_rob_i;
            nxt_dirty0 = lf_dirty0_i;
            nxt_dirty1 = lf_dirty1_i;
            nxt_data0  = lf_data0_i;
            nxt_data1  = lf_data1_i;
        end else if (grant[SRC_WB]) begin
            nxt_opcode = OP_WB;
            nxt_swo    = wb_swo_i;
            nxt_dirty0 = wb_dirty0_i;
            nxt_dirty1 = wb_dirty1_i;
        end else if (grant[SRC_WR]) begin
            nxt_opcode  = OP_WRITE;
            nxt_swo     = wr_swo_i;
            nxt_wbuf_id = wr_wbuf_id_i;
        end else if (grant[SRC_RD]) begin
            nxt_opcode = OP_READ;
            nxt_swo    = rd_swo_i;
            nxt_ch     = rd_ch_i;
            nxt_rob    = rd_rob_i;
        end
    end

    // Issue valid: reset clears it at once, discarding any pending entry.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            isu_sc_valid_o <= 1'b0;
        end else if (load_en) begin
            isu_sc_valid_o <= |grant;
        end
    end

    // Issue fields: load from the winner on every accepted transfer.
    // NOTE: datapath fields are qualified by isu_sc_valid_o, so they carry no reset.
    always_ff @(posedge clk_i) begin
        if (load_en && (|grant)) begin
            isu_sc_opcode_o                  <= nxt_opcode;
            isu_sc_set_way_offset_o          <= nxt_swo;
            isu_sc_channel_id_o              <= nxt_ch;
            isu_sc_xbar_rob_num_o            <= nxt_rob;
            isu_sc_wbuffer_id_o              <= nxt_wbuf_id;
            isu_sc_cacheline_dirty_offset0_o <= nxt_dirty0;
            isu_sc_cacheline_dirty_offset1_o <= nxt_dirty1;
            isu_sc_linefill_data_offset0_o   <= nxt_data0;
            isu_sc_linefill_data_offset1_o   <= nxt_data1;
        end
    end

endmodule : bank_isu_scheduler
